// File: rtl/pipe_hazard_unit_if.sv
// Hazard-unit bundle: ID-stage request fields in, stall/flush/forward controls out.
interface pipe_hazard_unit_if #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned CNT_W      = 16
);
    localparam int unsigned SEL_W = $clog2(FWD_STAGES + 1);

    logic             enable;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_dst;
    logic             id_reg_write;
    logic             id_mem_to_reg;
    logic             branch_taken;
    logic             stall;
    logic             flush_if;
    logic [SEL_W-1:0] fwd_a;
    logic [SEL_W-1:0] fwd_b;
    logic [CNT_W-1:0] stall_count;

    // Hazard unit side
    modport slave (
        input  enable, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dst, id_reg_write, id_mem_to_reg, branch_taken,
        output stall, flush_if, fwd_a, fwd_b, stall_count
    );

    // Pipeline-control side
    modport master (
        output enable, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dst, id_reg_write, id_mem_to_reg, branch_taken,
        input  stall, flush_if, fwd_a, fwd_b, stall_count
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Five-stage pipeline hazard unit: in-flight destination scoreboard (EX..WB),
// load-use stall, branch flush, operand forwarding selects, saturating stall count.
module pipe_hazard_unit #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_unit_if.slave  hz
);
    localparam int unsigned SEL_W = $clog2(FWD_STAGES + 1);

    // Scoreboard: slot 0 = EX, slot k = k stages after EX
    logic [FWD_STAGES:0] r_vld;
    logic [FWD_STAGES:0] r_rw;
    logic [FWD_STAGES:0] r_m2r;
    logic [REG_W-1:0]    r_dst [0:FWD_STAGES];
    // Source operands of the instruction currently in EX
    logic [REG_W-1:0]    r_rs;
    logic [REG_W-1:0]    r_rt;
    logic                r_urs;
    logic                r_urt;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_load_hit;
    logic                w_stall;
    logic                w_flush;
    logic [SEL_W-1:0]    w_fwd_a;
    logic [SEL_W-1:0]    w_fwd_b;

    function automatic logic hit(input logic vld, input logic rw,
                                 input logic [REG_W-1:0] dst,
                                 input logic [REG_W-1:0] r);
        return vld && rw && (dst == r) && (r != '0);
    endfunction

    // Load-use stall: a load still too young to forward feeds a used ID source
    always_comb begin
        w_load_hit = 1'b0;
        for (int unsigned p = 0; p < LOAD_LAT; p++) begin
            if (r_m2r[p] &&
                ((hz.id_uses_rs && hit(r_vld[p], r_rw[p], r_dst[p], hz.id_rs)) ||
                 (hz.id_uses_rt && hit(r_vld[p], r_rw[p], r_dst[p], hz.id_rt))))
                w_load_hit = 1'b1;
        end
        w_stall = hz.id_valid && hz.enable && w_load_hit;
        w_flush = hz.branch_taken && hz.enable && !w_stall;
    end

    // Forward selects: walk oldest to youngest so the youngest producer wins
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        for (int unsigned i = 0; i < FWD_STAGES; i++) begin
            int unsigned k;
            k = FWD_STAGES - i;
            if (r_urs && hit(r_vld[k], r_rw[k], r_dst[k], r_rs) &&
                (!r_m2r[k] || k > LOAD_LAT))
                w_fwd_a = SEL_W'(k);
            if (r_urt && hit(r_vld[k], r_rw[k], r_dst[k], r_rt) &&
                (!r_m2r[k] || k > LOAD_LAT))
                w_fwd_b = SEL_W'(k);
        end
    end

    // Scoreboard shift; a stalled or empty ID slot enters EX as a cleared bubble
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld <= '0;
            r_rw  <= '0;
            r_m2r <= '0;
            for (int unsigned k = 0; k <= FWD_STAGES; k++)
                r_dst[k] <= '0;
            r_rs  <= '0;
            r_rt  <= '0;
            r_urs <= 1'b0;
            r_urt <= 1'b0;
        end else if (hz.enable) begin
            for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_rw[k]  <= r_rw[k-1];
                r_m2r[k] <= r_m2r[k-1];
                r_dst[k] <= r_dst[k-1];
            end
            if (hz.id_valid && !w_stall) begin
                r_vld[0] <= 1'b1;
                r_rw[0]  <= hz.id_reg_write;
                r_m2r[0] <= hz.id_mem_to_reg;
                r_dst[0] <= hz.id_dst;
                r_rs     <= hz.id_rs;
                r_rt     <= hz.id_rt;
                r_urs    <= hz.id_uses_rs;
                r_urt    <= hz.id_uses_rt;
            end else begin
                r_vld[0] <= 1'b0;
                r_rw[0]  <= 1'b0;
                r_m2r[0] <= 1'b0;
                r_dst[0] <= '0;
                r_rs     <= '0;
                r_rt     <= '0;
                r_urs    <= 1'b0;
                r_urt    <= 1'b0;
            end
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge clk) begin
        if (!rst)
            r_cnt <= '0;
        else if (w_stall && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign hz.stall       = w_stall;
    assign hz.flush_if    = w_flush;
    assign hz.fwd_a       = w_fwd_a;
    assign hz.fwd_b       = w_fwd_b;
    assign hz.stall_count = r_cnt;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: default build plus LOAD_LAT=2/FWD_STAGES=3/CNT_W=4 build.
module tb_pipe_hazard_unit;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipe_hazard_unit_if #(.REG_W(5), .FWD_STAGES(2), .CNT_W(16)) hz0 ();
    pipe_hazard_unit_if #(.REG_W(5), .FWD_STAGES(3), .CNT_W(4))  hz1 ();

    pipe_hazard_unit #(.REG_W(5), .FWD_STAGES(2), .LOAD_LAT(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst_n), .hz(hz0.slave)
    );
    pipe_hazard_unit #(.REG_W(5), .FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst_n), .hz(hz1.slave)
    );

    typedef struct packed {
        logic       vld;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dst;
        logic       rw;
        logic       m2r;
    } ins_t;

    typedef struct {
        bit          dut;
        bit          rstn;
        bit          en;
        bit          br;
        ins_t        ins;
        bit          s;
        bit          f;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int          idx;
        bit          dut;
        bit          s;
        bit          f;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic ins_t ALU(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        return '{vld: 1'b1, rs: s, rt: t, urs: 1'b1, urt: 1'b1, dst: d, rw: 1'b1, m2r: 1'b0};
    endfunction

    function automatic ins_t LW(input logic [4:0] d, input logic [4:0] base);
        return '{vld: 1'b1, rs: base, rt: 5'd0, urs: 1'b1, urt: 1'b0, dst: d, rw: 1'b1, m2r: 1'b1};
    endfunction

    function automatic ins_t NOP();
        return '0;
    endfunction

    function automatic int sat15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    // Rows with rstn=0 are reset cycles and are not compared
    function automatic void add(input bit dut, input bit rstn, input bit en, input bit br,
                                input ins_t ins, input bit s, input bit f,
                                input logic [1:0] fa, input logic [1:0] fb, input int cnt);
        vec_t v;
        v.dut = dut; v.rstn = rstn; v.en = en; v.br = br; v.ins = ins;
        v.s = s; v.f = f; v.fa = fa; v.fb = fb; v.cnt = 16'(cnt);
        vecs.push_back(v);
    endfunction

    function automatic void check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    task automatic drive(input vec_t v);
        rst_n = v.rstn;
        hz0.enable = v.en;          hz1.enable = v.en;
        hz0.branch_taken = v.br;    hz1.branch_taken = v.br;
        hz0.id_valid = v.ins.vld;   hz1.id_valid = v.ins.vld;
        hz0.id_rs = v.ins.rs;       hz1.id_rs = v.ins.rs;
        hz0.id_rt = v.ins.rt;       hz1.id_rt = v.ins.rt;
        hz0.id_uses_rs = v.ins.urs; hz1.id_uses_rs = v.ins.urs;
        hz0.id_uses_rt = v.ins.urt; hz1.id_uses_rt = v.ins.urt;
        hz0.id_dst = v.ins.dst;     hz1.id_dst = v.ins.dst;
        hz0.id_reg_write = v.ins.rw;   hz1.id_reg_write = v.ins.rw;
        hz0.id_mem_to_reg = v.ins.m2r; hz1.id_mem_to_reg = v.ins.m2r;
    endtask

    initial begin
        vec_t v0;
        // ---------------- default build (LOAD_LAT=1, FWD_STAGES=2) ----------------
        add(0, 0, 1, 0, NOP(),          0, 0, 0, 0, 0);
        add(0, 1, 1, 0, NOP(),          0, 0, 0, 0, 0);  // reset state
        add(0, 1, 1, 0, ALU(3, 1, 2),   0, 0, 0, 0, 0);  // add r3
        add(0, 1, 1, 0, ALU(4, 3, 5),   0, 0, 0, 0, 0);  // sub r4,r3,r5
        add(0, 1, 1, 0, NOP(),          0, 0, 1, 0, 0);  // sub in EX: fwd from MEM
        add(0, 1, 1, 0, ALU(3, 1, 2),   0, 0, 0, 0, 0);
        add(0, 1, 1, 0, ALU(8, 9, 10),  0, 0, 0, 0, 0);  // independent
        add(0, 1, 1, 0, ALU(4, 3, 5),   0, 0, 0, 0, 0);
        add(0, 1, 1, 0, NOP(),          0, 0, 2, 0, 0);  // fwd from WB
        add(0, 1, 1, 0, NOP(),          0, 0, 0, 0, 0);
        add(0, 1, 1, 0, LW(2, 0),       0, 0, 0, 0, 0);  // lw r2
        add(0, 1, 1, 0, ALU(6, 2, 2),   1, 0, 0, 0, 0);  // load-use stall
        add(0, 1, 1, 0, ALU(6, 2, 2),   0, 0, 0, 0, 1);
        add(0, 1, 1, 0, NOP(),          0, 0, 2, 2, 1);
        add(0, 1, 1, 0, ALU(0, 1, 2),   0, 0, 0, 0, 1);  // write r0
        add(0, 1, 1, 0, ALU(9, 0, 0),   0, 0, 0, 0, 1);  // read r0
        add(0, 1, 1, 0, NOP(),          0, 0, 0, 0, 1);
        add(0, 1, 1, 0, ALU(7, 1, 2),   0, 0, 0, 0, 1);  // r7 writer #1
        add(0, 1, 1, 0, ALU(7, 3, 4),   0, 0, 0, 0, 1);  // r7 writer #2
        add(0, 1, 1, 0, ALU(10, 7, 7),  0, 0, 0, 0, 1);
        add(0, 1, 1, 0, NOP(),          0, 0, 1, 1, 1);  // youngest wins
        add(0, 1, 1, 0, LW(2, 0),       0, 0, 0, 0, 1);
        add(0, 1, 0, 1, ALU(6, 2, 5),   0, 0, 0, 0, 1);  // frozen: no stall/flush
        add(0, 1, 1, 1, ALU(6, 2, 5),   1, 0, 0, 0, 1);  // stall beats branch
        add(0, 1, 1, 1, ALU(6, 2, 5),   0, 1, 0, 0, 2);  // flush once stall clears
        add(0, 1, 0, 0, NOP(),          0, 0, 2, 0, 2);
        add(0, 1, 0, 0, NOP(),          0, 0, 2, 0, 2);  // still frozen
        add(0, 1, 1, 0, NOP(),          0, 0, 2, 0, 2);
        add(0, 1, 1, 0, NOP(),          0, 0, 0, 0, 2);
        // ---------------- LOAD_LAT=2, FWD_STAGES=3, CNT_W=4 ----------------
        add(1, 0, 1, 0, NOP(),          0, 0, 0, 0, 0);
        add(1, 1, 1, 0, NOP(),          0, 0, 0, 0, 0);
        add(1, 1, 1, 0, LW(2, 0),       0, 0, 0, 0, 0);
        add(1, 1, 1, 0, ALU(6, 2, 2),   1, 0, 0, 0, 0);
        add(1, 1, 1, 0, ALU(6, 2, 2),   1, 0, 0, 0, 1);
        add(1, 1, 1, 0, ALU(6, 2, 2),   0, 0, 0, 0, 2);
        add(1, 1, 1, 0, NOP(),          0, 0, 3, 3, 2);
        add(1, 1, 1, 0, LW(2, 0),       0, 0, 0, 0, 2);
        add(1, 1, 1, 0, ALU(8, 9, 10),  0, 0, 0, 0, 2);
        add(1, 1, 1, 0, ALU(6, 2, 2),   1, 0, 0, 0, 2);
        add(1, 1, 1, 0, ALU(6, 2, 2),   0, 0, 0, 0, 3);
        add(1, 1, 1, 0, NOP(),          0, 0, 3, 3, 3);
        // saturation: 2 stalls per lw/use pair, counter caps at 15
        add(1, 0, 1, 0, NOP(),          0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            add(1, 1, 1, 0, LW(2, 0),     0, 0, (i == 0) ? 2'd0 : 2'd3,
                (i == 0) ? 2'd0 : 2'd3, sat15(2 * i));
            add(1, 1, 1, 0, ALU(6, 2, 2), 1, 0, 0, 0, sat15(2 * i));
            add(1, 1, 1, 0, ALU(6, 2, 2), 1, 0, 0, 0, sat15(2 * i + 1));
            add(1, 1, 1, 0, ALU(6, 2, 2), 0, 0, 0, 0, sat15(2 * i + 2));
        end
        add(1, 1, 1, 0, LW(2, 0),       0, 0, 3, 3, 15);
        add(1, 1, 1, 0, ALU(6, 2, 2),   1, 0, 0, 0, 15);
        add(1, 0, 1, 0, ALU(6, 2, 2),   0, 0, 0, 0, 0);  // reset mid-stall
        add(1, 1, 1, 0, ALU(6, 2, 2),   0, 0, 0, 0, 0);  // no residual stall
        add(1, 1, 1, 0, NOP(),          0, 0, 0, 0, 0);

        v0.dut = 0; v0.rstn = 0; v0.en = 1; v0.br = 0; v0.ins = NOP();
        v0.s = 0; v0.f = 0; v0.fa = 0; v0.fb = 0; v0.cnt = 0;
        drive(v0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            if (vecs[i].rstn) begin
                exp_t e;
                e.idx = i; e.dut = vecs[i].dut; e.s = vecs[i].s; e.f = vecs[i].f;
                e.fa = vecs[i].fa; e.fb = vecs[i].fb; e.cnt = vecs[i].cnt;
                exp_q.push_back(e);
            end
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t e;
                logic        a_s, a_f;
                logic [1:0]  a_fa, a_fb;
                logic [15:0] a_cnt;
                e = exp_q.pop_front();
                a_s   = e.dut ? hz1.stall    : hz0.stall;
                a_f   = e.dut ? hz1.flush_if : hz0.flush_if;
                a_fa  = e.dut ? hz1.fwd_a    : hz0.fwd_a;
                a_fb  = e.dut ? hz1.fwd_b    : hz0.fwd_b;
                a_cnt = e.dut ? 16'(hz1.stall_count) : hz0.stall_count;
                check($sformatf("v%0d.stall", e.idx),       16'(a_s),  16'(e.s));
                check($sformatf("v%0d.flush_if", e.idx),    16'(a_f),  16'(e.f));
                check($sformatf("v%0d.fwd_a", e.idx),       16'(a_fa), 16'(e.fa));
                check($sformatf("v%0d.fwd_b", e.idx),       16'(a_fb), 16'(e.fb));
                check($sformatf("v%0d.stall_count", e.idx), a_cnt,     e.cnt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard-detection and forwarding controller for the five-stage pipeline, replacing the fixed two-source forwarding unit and single-cycle load-use detector. It keeps its own scoreboard of in-flight destinations from EX through WB, drives the IF/ID stall, the IF flush on a taken branch and the forwarding-mux selects for both ALU operands. It also keeps a saturating stall counter. Forward depth and load latency are parameters.

## Interface
Parameters:
- REG_W, 5, register-address width.
- FWD_STAGES, 2, tracked stages after EX (1 = MEM, 2 = WB, …); legal 2..6.
- LOAD_LAT, 1, stages after EX before load data is forwardable; legal 1 ≤ LOAD_LAT < FWD_STAGES.
- CNT_W, 16, stall-counter width.
- SEL_W is derived: $clog2(FWD_STAGES+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- enable  in  1  global advance; 0 freezes all state.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_W  ID source registers.
- id_uses_rs, id_uses_rt  in  1  source is actually read.
- id_dst  in  REG_W  ID destination register.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_to_reg  in  1  ID instruction is a load.
- branch_taken  in  1  branch resolved taken in ID.
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- flush_if  out  1  discard the instruction entering IF/ID.
- fwd_a, fwd_b  out  SEL_W  operand select: 0 = ID/EX data, k = result of stage k.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- Scoreboard has FWD_STAGES+1 slots: slot 0 = EX, slot k = stage k. Each slot holds {valid, dst, reg_write, mem_to_reg}. Slot 0 also holds rs, rt, uses_rs and uses_rt.
- Shift rule: on a clock edge with rst=1 and enable=1, slot k ← slot k−1.
- Slot 0 ← ID fields when id_valid & ~stall. Otherwise slot 0 becomes a bubble with valid=0.
- The slot FWD_STAGES entry is discarded on shift. The register file is write-before-read, so no forwarding beyond WB is needed.
- A slot k is a "hit" for register r when valid & reg_write & dst==r & r≠0.
- Load-use stall: stall = id_valid & enable & ∃ slot p (0 ≤ p < LOAD_LAT) that is a hit for a used ID source and has mem_to_reg=1.
  - Bubbles advance the load, so the stall lasts LOAD_LAT−p cycles.
- Forwarding for operand A uses slot-0 rs and uses_rs. fwd_a = smallest k in 1..FWD_STAGES where slot k is a hit for rs and (mem_to_reg=0 or k > LOAD_LAT). If there is none, fwd_a = 0. Operand B is the same with rt.
- Youngest producer wins. An unused source always gives select 0.
- flush_if = branch_taken & enable & ~stall.
  - Stall beats branch: the branch stays in ID and flush_if asserts on the cycle the stall clears.
- stall_count increments on each edge where stall=1 and enables are active. It saturates at 2^CNT_W−1 and never wraps.
- enable=0: no shift, no counting. stall and flush_if are 0. fwd_a and fwd_b still reflect the frozen scoreboard.

## Timing
- stall, flush_if, fwd_a and fwd_b are combinational from the inputs and scoreboard, valid in the same cycle. There are no registered outputs except stall_count.
- The scoreboard updates one edge after ID is sampled. A producer issued at edge n is in slot k after edge n+k.
- Reset (rst=0 at an edge): all slots invalid and stall_count=0. Consequently stall=0, flush_if=0, fwd_a=fwd_b=0 from the next cycle on.
- Reset mid-stall or mid-forward drops all in-flight entries. No residual stall follows.
- rst has priority over enable.

## Test plan
- Defaults, ALU chain `add r3,…` then `sub r4,r3,r5`: fwd_a=1 in the cycle `sub` is in EX and stall is never raised. Insert one independent instruction between them: fwd_a=2.
- Defaults, `lw r2` then `add r6,r2,r2`: stall=1 for exactly 1 cycle and stall_count=1. Then fwd_a=fwd_b=2.
- LOAD_LAT=2, FWD_STAGES=3: `lw r2` then dependent instruction: stall=1 for 2 cycles, then fwd_a=3. With one independent instruction between them: 1 stall cycle.
- Write to r0 followed by a reader of r0: fwd_a=0 and stall=0. Two in-flight writers of r7, in slots 1 and 2: fwd_a=1.
- branch_taken=1 during a load-use stall: flush_if=0 while stall=1. flush_if=1 on the next cycle. With enable=0: stall=flush_if=0 and the scoreboard is unchanged.
- Preload stall_count to max with CNT_W=4 (15 stalls), then cause 3 more stalls: stall_count stays 15. Assert rst=0 mid-stall: stall=0 and count=0 after the edge.
